// File: rtl/icache_cacop_unit_if.sv
// ---------------------------------------------------------------------------
// icache_cacop_unit_if
//   Request/response channels between the memory block, the ICache CACOP
//   unit and writeback.
//   Request  : req_valid_i / req_ready_o handshake carrying vaddr, CACOP code
//              and the ROB index of the issuing instruction.
//   Response : rsp_valid_o / rsp_ready_i handshake carrying ROB index, vaddr
//              and the translation exception (flag + ecode).
//   master   : the requester / writeback side.
//   slave    : the CACOP unit.
// ---------------------------------------------------------------------------
interface icache_cacop_unit_if #(
  parameter int ROB_IDX_WIDTH = 6
) ();
  logic                     req_valid_i;
  logic                     req_ready_o;
  logic [31:0]              req_vaddr_i;
  logic [4:0]               req_code_i;
  logic [ROB_IDX_WIDTH-1:0] req_rob_idx_i;

  logic                     rsp_valid_o;
  logic                     rsp_ready_i;
  logic [ROB_IDX_WIDTH-1:0] rsp_rob_idx_o;
  logic [31:0]              rsp_vaddr_o;
  logic                     rsp_excp_o;
  logic [5:0]               rsp_ecode_o;

  modport master (
    output req_valid_i, req_vaddr_i, req_code_i, req_rob_idx_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rob_idx_o, rsp_vaddr_o, rsp_excp_o,
           rsp_ecode_o
  );

  modport slave (
    input  req_valid_i, req_vaddr_i, req_code_i, req_rob_idx_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rob_idx_o, rsp_vaddr_o, rsp_excp_o,
           rsp_ecode_o
  );
endinterface

// File: rtl/icache_cacop_unit.sv
// ---------------------------------------------------------------------------
// icache_cacop_unit
//   Executes ICache CACOP operations one at a time.
//     op 0 (store-tag init) / op 1 (index invalidate): clear the tag entry at
//       the set/way selected directly by the virtual address.
//     op 2/3 (hit invalidate): translate through the MMU, read all ways of
//       the set, clear the lowest-numbered way whose {valid,tag} matches.
//   Ports:
//     clk, a_rst_n        clock, asynchronous active-low reset
//     flush_i             pipeline flush, abandons the op without response
//     cacop               request/response channels (slave modport)
//     trans_*             MMU translation request/response
//     tag_rd_*            tag RAM read port (data one cycle after enable)
//     tag_w*              tag RAM write port (one-hot way)
//     busy_o              high whenever an op is in flight (stalls fetch)
// ---------------------------------------------------------------------------
module icache_cacop_unit #(
  parameter int  IDX_WIDTH     = 8,
  parameter int  WAYS          = 2,
  parameter int  ROB_IDX_WIDTH = 6,
  localparam int TAG_W         = 26 - IDX_WIDTH
) (
  input  logic                        clk,
  input  logic                        a_rst_n,
  input  logic                        flush_i,
  icache_cacop_unit_if.slave          cacop,
  output logic                        trans_req_valid_o,
  output logic [31:0]                 trans_vaddr_o,
  input  logic                        trans_rsp_valid_i,
  input  logic [31:0]                 trans_paddr_i,
  input  logic                        trans_excp_i,
  input  logic [5:0]                  trans_ecode_i,
  output logic                        tag_rd_en_o,
  output logic [IDX_WIDTH-1:0]        tag_rd_idx_o,
  input  logic [WAYS*(TAG_W+1)-1:0]   tag_rd_data_i,
  output logic                        tag_we_o,
  output logic [IDX_WIDTH-1:0]        tag_wr_idx_o,
  output logic [WAYS-1:0]             tag_wr_way_o,
  output logic [TAG_W:0]              tag_wr_data_o,
  output logic                        busy_o
);

  localparam int WAY_BITS = $clog2(WAYS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_TRANS  = 3'd1;
  localparam logic [2:0] S_LOOKUP = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  // NOTE: the external reset is asserted asynchronously but released through
  // two flops, so every state flop leaves reset on the same clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [2:0]               state_q, state_d;
  logic [31:0]              vaddr_q;
  logic [ROB_IDX_WIDTH-1:0] rob_q;
  logic [TAG_W-1:0]         ptag_q;
  logic [WAYS-1:0]          way_q;
  logic                     excp_q;
  logic [5:0]               ecode_q;

  logic                     accept;
  logic                     hit_op;
  logic                     trans_done;
  logic [WAYS-1:0]          hit_oh;
  logic                     hit_found;

  assign accept     = cacop.req_valid_i & cacop.req_ready_o;
  assign hit_op     = cacop.req_code_i[4];   // ops 2 and 3
  assign trans_done = (state_q == S_TRANS) & trans_rsp_valid_i & ~flush_i;

  // Lowest-numbered way whose {valid,tag} equals {1, physical tag}.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    hit_oh    = '0;
    hit_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_found &&
          tag_rd_data_i[w*(TAG_W+1) +: TAG_W+1] == {1'b1, ptag_q}) begin
        hit_oh[w] = 1'b1;
        hit_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = hit_op ? S_TRANS : S_WRITE;
      S_TRANS:  if (flush_i)                state_d = S_IDLE;
                else if (trans_rsp_valid_i) state_d = trans_excp_i ? S_RESP : S_LOOKUP;
      S_LOOKUP: if (flush_i)                state_d = S_IDLE;
                else                        state_d = hit_found ? S_WRITE : S_RESP;
      // The write itself is never abandoned; flush only suppresses the response.
      S_WRITE:  state_d = flush_i ? S_IDLE : S_RESP;
      S_RESP:   if (flush_i || cacop.rsp_ready_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vaddr_q <= '0;
      rob_q   <= '0;
      ptag_q  <= '0;
      way_q   <= '0;
      excp_q  <= 1'b0;
      ecode_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        vaddr_q <= cacop.req_vaddr_i;
        rob_q   <= cacop.req_rob_idx_i;
        excp_q  <= 1'b0;
        ecode_q <= '0;
        // Direct-addressed ops pick the way from the low vaddr bits.
        way_q   <= {{(WAYS-1){1'b0}}, 1'b1} << cacop.req_vaddr_i[WAY_BITS-1:0];
      end
      if (trans_done) begin
        if (trans_excp_i) begin
          excp_q  <= 1'b1;
          ecode_q <= trans_ecode_i;
        end else begin
          ptag_q  <= trans_paddr_i[31:IDX_WIDTH+6];
        end
      end
      if (state_q == S_LOOKUP) way_q <= hit_oh;
    end
  end

  assign cacop.req_ready_o   = (state_q == S_IDLE);
  assign busy_o              = (state_q != S_IDLE);

  assign trans_req_valid_o   = (state_q == S_TRANS);
  assign trans_vaddr_o       = vaddr_q;

  // Read issued on the translation-complete cycle so data lands in LOOKUP.
  assign tag_rd_en_o         = trans_done & ~trans_excp_i;
  assign tag_rd_idx_o        = vaddr_q[IDX_WIDTH+5:6];

  assign tag_we_o            = (state_q == S_WRITE);
  assign tag_wr_idx_o        = vaddr_q[IDX_WIDTH+5:6];
  assign tag_wr_way_o        = way_q;
  assign tag_wr_data_o       = '0;

  assign cacop.rsp_valid_o   = (state_q == S_RESP);
  assign cacop.rsp_rob_idx_o = rob_q;
  assign cacop.rsp_vaddr_o   = vaddr_q;
  assign cacop.rsp_excp_o    = excp_q;
  assign cacop.rsp_ecode_o   = ecode_q;

  // Sub-op bits and the page offset of the physical address play no part here.
  logic unused_bits;
  assign unused_bits = ^{cacop.req_code_i[2:0], trans_paddr_i[IDX_WIDTH+5:0]};

endmodule
